// File: rtl/uart_pkg.sv
// Shared types for the UART byte path: byte type and drain FSM states.
package uart_pkg;

    typedef logic [7:0] byte_t;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT_LO = 2'd2;
    localparam logic [1:0] WAIT_HI = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = IDLE,
        S_ISSUE   = ISSUE,
        S_WAIT_LO = WAIT_LO,
        S_WAIT_HI = WAIT_HI
    } state_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x 8 register file: one synchronous write port,
// one combinational read port.
module fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  byte_t             wdata,
    input  logic [ADDR_W-1:0] raddr,
    output byte_t             rdata
);

    byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_byte_fifo.sv
// Elastic byte buffer from uart_rx to uart_tx with edge-detected
// push, sticky overflow and a rdy/en drain FSM.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int GUARD  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx_valid,
    input  byte_t           rx_data,
    input  logic            tx_rdy,
    output logic            tx_en,
    output byte_t           tx_data,
    output logic [ADDR_W:0] count,
    output logic            empty,
    output logic            full,
    output logic            overflow,
    input  logic            ovf_clr
);

    localparam int GW = $clog2(GUARD) + 1;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              vld_d;
    logic              push;
    logic              pop;
    logic              wr_en;
    byte_t             rd_byte;
    state_t            state;
    logic [GW-1:0]     guard;

    assign push  = rx_valid & ~vld_d;
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign pop   = (state == S_IDLE) & ~empty & tx_rdy;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign wr_en = push & (~full | pop);

    fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (rx_data),
        .raddr (rd_ptr),
        .rdata (rd_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_d    <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            vld_d <= rx_valid;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en & ~pop) begin
                count <= count + 1'b1;
            end else if (pop & ~wr_en) begin
                count <= count - 1'b1;
            end
            if (push & full & ~pop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            guard   <= '0;
            tx_en   <= 1'b0;
            tx_data <= '0;
        end else begin
            tx_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        tx_data <= rd_byte;
                        tx_en   <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    guard <= '0;
                    state <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (!tx_rdy) begin
                        state <= S_WAIT_HI;
                    end else if (guard < GUARD_LAST) begin
                        guard <= guard + 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT_HI: begin
                    if (tx_rdy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Randomized scoreboard bench for uart_byte_fifo with a
// queue-based reference model and a reactive transmitter model.
module tb_uart_byte_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int GUARD  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            rx_valid;
    logic [7:0]      rx_data;
    logic            tx_rdy;
    logic            tx_en;
    logic [7:0]      tx_data;
    logic [ADDR_W:0] count;
    logic            empty;
    logic            full;
    logic            overflow;
    logic            ovf_clr;

    uart_byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .GUARD  (GUARD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_rdy   (tx_rdy),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb[$];
    int mcount = 0;
    bit movf = 1'b0;
    bit prev_v = 1'b1;
    int cyc = 0;
    int last_en = -100;
    int en_cnt = 0;
    int en_times[$];

    int mode = 0;
    bit rdy_force = 1'b0;
    int busy_len = 1;
    bit rand_busy = 1'b0;

    function automatic void chk(string nm, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     nm, got, want, cyc);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        step();
    endtask

    task automatic wait_drain(input int limit, input string nm);
        int n = 0;
        while ((sb.size() != 0 || mcount != 0) && n < limit) begin
            step();
            n++;
        end
        if (n >= limit) begin
            checks++;
            errors++;
            $display("FAIL %s: drain timeout, %0d bytes left",
                     nm, sb.size());
        end
        repeat (10) step();
    endtask

    // Reference model: FIFO contents as a queue, one push per
    // rising edge of rx_valid, one pop per observed tx_en pulse.
    always begin
        bit p_push;
        bit p_pop;
        bit drop;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            sb.delete();
            mcount = 0;
            movf = 1'b0;
            prev_v = 1'b1;
            last_en = -100;
        end else begin
            p_push = rx_valid && !prev_v;
            prev_v = rx_valid;
            p_pop = tx_en;
            if (p_pop && mcount == 0) begin
                chk("pop_when_empty", 1, 0);
            end
            drop = p_push && mcount == DEPTH && !p_pop;
            if (p_push && !drop) begin
                sb.push_back(rx_data);
            end
            mcount += int'(p_push && !drop) - int'(p_pop && mcount > 0);
            if (drop) begin
                movf = 1'b1;
            end else if (ovf_clr) begin
                movf = 1'b0;
            end
        end
    end

    // Monitor: status flags every cycle, data on every tx_en.
    always begin
        @(negedge clk);
        chk("count", int'(count), mcount);
        chk("empty", int'(empty), int'(mcount == 0));
        chk("full", int'(full), int'(mcount == DEPTH));
        chk("overflow", int'(overflow), int'(movf));
        if (tx_en) begin
            chk("en_spacing", int'(cyc - last_en >= 4), 1);
            last_en = cyc;
            en_cnt++;
            en_times.push_back(cyc);
            if (sb.size() == 0) begin
                chk("tx_unexpected", 1, 0);
            end else begin
                chk("tx_data", int'(tx_data), int'(sb.pop_front()));
            end
        end
    end

    // Transmitter model: forced level, or drop rdy after each en.
    initial begin
        bit e;
        int busy = 0;
        tx_rdy = 1'b0;
        forever begin
            @(negedge clk);
            e = tx_en;
            @(posedge clk);
            #1;
            if (mode == 0) begin
                tx_rdy = rdy_force;
            end else if (e) begin
                tx_rdy = 1'b0;
                busy = rand_busy ? int'($urandom_range(1, 6)) : busy_len;
            end else if (busy > 0) begin
                busy--;
                tx_rdy = (busy == 0);
            end else begin
                tx_rdy = 1'b1;
            end
        end
    end

    initial begin
        int e0;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        ovf_clr = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // single byte, level held 10 cycles
        mode = 0;
        rdy_force = 1'b1;
        e0 = en_cnt;
        rx_data = 8'h41;
        rx_valid = 1'b1;
        repeat (10) step();
        rx_valid = 1'b0;
        repeat (10) step();
        chk("single_en_count", en_cnt - e0, 1);
        chk("single_tx_data", int'(tx_data), 8'h41);

        // burst held off, then drained by a responsive transmitter
        rdy_force = 1'b0;
        repeat (3) step();
        e0 = en_cnt;
        for (int i = 1; i <= 5; i++) begin
            push_byte(8'(i));
        end
        step();
        chk("burst_count", int'(count), 5);
        chk("burst_no_en", en_cnt - e0, 0);
        mode = 1;
        busy_len = 1;
        wait_drain(200, "burst");
        chk("burst_en_count", en_cnt - e0, 5);

        // overflow: DEPTH+2 pushes with transmitter stalled
        mode = 0;
        rdy_force = 1'b0;
        repeat (5) step();
        for (int i = 0; i < DEPTH + 2; i++) begin
            push_byte(8'(8'h80 + i));
        end
        chk("ovf_count", int'(count), DEPTH);
        chk("ovf_full", int'(full), 1);
        chk("ovf_flag", int'(overflow), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_cleared", int'(overflow), 0);

        // full FIFO: rdy rises on the same edge as a push
        rdy_force = 1'b1;
        step();
        rx_data = 8'hc3;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        chk("fullpp_count", int'(count), DEPTH);
        chk("fullpp_ovf", int'(overflow), 0);
        wait_drain(400, "fullpp");

        // guard timeout: rdy stuck high
        en_times.delete();
        e0 = en_cnt;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        wait_drain(200, "guard");
        chk("guard_en_count", en_cnt - e0, 3);
        for (int i = 1; i < en_times.size(); i++) begin
            chk("guard_gap_max",
                int'(en_times[i] - en_times[i-1] <= GUARD + 2), 1);
        end
        chk("guard_empty", int'(empty), 1);

        // reset while waiting for rdy high, valid held across it
        mode = 1;
        busy_len = 10;
        push_byte(8'h61);
        push_byte(8'h62);
        push_byte(8'h63);
        rx_data = 8'h64;
        rx_valid = 1'b1;
        step();
        step();
        chk("pre_rst_count", int'(count), 3);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (5) step();
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_tx_en", int'(tx_en), 0);
        rx_valid = 1'b0;
        step();
        push_byte(8'h77);
        wait_drain(200, "post_rst");

        // randomized traffic with random transmitter busy times
        rand_busy = 1'b1;
        for (int i = 0; i < 600; i++) begin
            rx_data = 8'($urandom);
            rx_valid = ($urandom_range(0, 2) != 0);
            ovf_clr = ($urandom_range(0, 30) == 0);
            step();
        end
        rx_valid = 1'b0;
        ovf_clr = 1'b0;
        wait_drain(1000, "random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
